// File: rtl/regfile_bus_sequencer_pkg.sv
// Shared opcodes, state codes and field types for the
// register-file / databus micro-sequencer.
package regfile_bus_sequencer_pkg;

  localparam int SEL_W = 2;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_XFER     = 3'd1;
  localparam logic [2:0] ST_ALU_A    = 3'd2;
  localparam logic [2:0] ST_ALU_WAIT = 3'd3;
  localparam logic [2:0] ST_ALU_WB   = 3'd4;
  localparam logic [2:0] ST_OUT      = 3'd5;

  typedef struct packed {
    logic [1:0]       op;
    logic [SEL_W-1:0] rd;
    logic [SEL_W-1:0] rs;
    logic [7:0]       imm;
  } instr_t;

endpackage

// File: rtl/regfile_bus_sequencer.sv
// Sequences MOV/LDI/ALU/OUT transfers onto the shared databus,
// one instruction at a time, with a single bus driver per cycle.
module regfile_bus_sequencer #(
  parameter int ALU_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs,
  input  logic [7:0]       instr_imm,
  output logic             reg_load,
  output logic             reg_enable,
  output logic [1:0]       in_regselect,
  output logic [1:0]       out_regselect,
  output logic [1:0]       alu_regselect,
  output logic             imm_drive,
  output logic [7:0]       imm_bus,
  output logic             alu_latch,
  output logic             alu_drive,
  output logic             port_load,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  import regfile_bus_sequencer_pkg::*;

  localparam logic [3:0] WAIT_INIT =
    4'(ALU_WAIT > 0 ? ALU_WAIT - 1 : 0);

  logic [2:0] state;
  logic [2:0] state_nx;
  instr_t     lat;
  logic [3:0] wait_cnt;
  logic       accept;

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (instr_op)
            OP_MOV:  state_nx = ST_XFER;
            OP_LDI:  state_nx = ST_XFER;
            OP_ALU:  state_nx = ST_ALU_A;
            default: state_nx = ST_OUT;
          endcase
        end
      end
      ST_ALU_A:
        state_nx = (ALU_WAIT > 0) ? ST_ALU_WAIT : ST_ALU_WB;
      ST_ALU_WAIT:
        if (wait_cnt == 4'd0) state_nx = ST_ALU_WB;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      lat      <= '0;
      wait_cnt <= 4'd0;
      retired  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat <= '{op: instr_op, rd: instr_rd,
                 rs: instr_rs, imm: instr_imm};
      end
      // Counter is primed while still in ALU_A, i.e. on entry to the wait.
      if (state == ST_ALU_A) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_ALU_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (done) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    instr_ready   = (state == ST_IDLE);
    reg_load      = 1'b0;
    reg_enable    = 1'b0;
    in_regselect  = '0;
    out_regselect = '0;
    alu_regselect = '0;
    imm_drive     = 1'b0;
    imm_bus       = '0;
    alu_latch     = 1'b0;
    alu_drive     = 1'b0;
    port_load     = 1'b0;
    done          = 1'b0;
    unique case (1'b1)
      (state == ST_XFER): begin
        reg_load     = 1'b1;
        in_regselect = lat.rd;
        done         = 1'b1;
        if (lat.op == OP_LDI) begin
          imm_drive = 1'b1;
          imm_bus   = lat.imm;
        end else begin
          reg_enable    = 1'b1;
          out_regselect = lat.rs;
        end
      end
      (state == ST_ALU_A): begin
        reg_enable    = 1'b1;
        out_regselect = lat.rd;
        alu_regselect = lat.rs;
        alu_latch     = 1'b1;
      end
      (state == ST_ALU_WB): begin
        alu_drive     = 1'b1;
        reg_load      = 1'b1;
        in_regselect  = lat.rd;
        alu_regselect = lat.rs;
        done          = 1'b1;
      end
      (state == ST_OUT): begin
        reg_enable    = 1'b1;
        out_regselect = lat.rs;
        port_load     = 1'b1;
        done          = 1'b1;
      end
      default: begin
      end
    endcase
  end

  a_bus_excl: assert property (@(posedge clock) disable iff (reset)
    $onehot0({reg_enable, imm_drive, alu_drive}));

endmodule

// File: tb/tb_regfile_bus_sequencer.sv
// Directed and random bench for the databus sequencer, with a
// per-cycle instruction-level reference model.
module tb_regfile_bus_sequencer;

  localparam int W  = 2;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [1:0]    instr_rd;
  logic [1:0]    instr_rs;
  logic [7:0]    instr_imm;
  logic          reg_load;
  logic          reg_enable;
  logic [1:0]    in_regselect;
  logic [1:0]    out_regselect;
  logic [1:0]    alu_regselect;
  logic          imm_drive;
  logic [7:0]    imm_bus;
  logic          alu_latch;
  logic          alu_drive;
  logic          port_load;
  logic          done;
  logic [CW-1:0] retired;

  regfile_bus_sequencer #(.ALU_WAIT(W), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs(instr_rs), .instr_imm(instr_imm),
    .reg_load(reg_load), .reg_enable(reg_enable),
    .in_regselect(in_regselect),
    .out_regselect(out_regselect),
    .alu_regselect(alu_regselect),
    .imm_drive(imm_drive), .imm_bus(imm_bus),
    .alu_latch(alu_latch), .alu_drive(alu_drive),
    .port_load(port_load), .done(done), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rdy;
    logic       rl;
    logic       re;
    logic [1:0] is;
    logic [1:0] os;
    logic [1:0] as;
    logic       id;
    logic [7:0] ib;
    logic       al;
    logic       ad;
    logic       pl;
    logic       dn;
  } obs_t;

  obs_t act;
  assign act = {instr_ready, reg_load, reg_enable, in_regselect,
                out_regselect, alu_regselect, imm_drive, imm_bus,
                alu_latch, alu_drive, port_load, done};

  obs_t          q[$];
  logic [CW-1:0] mret;
  bit            armed = 0;
  int            nchk  = 0;
  int            nerr  = 0;
  int            cyc   = 0;

  function automatic obs_t idle_o();
    obs_t o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  // Expected per-cycle outputs for one accepted instruction.
  task automatic push_instr(input logic [1:0] op, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [7:0] imm);
    obs_t o;
    o = '0;
    case (op)
      2'b00: begin
        o.re = 1; o.os = rs; o.rl = 1; o.is = rd; o.dn = 1;
        q.push_back(o);
      end
      2'b01: begin
        o.id = 1; o.ib = imm; o.rl = 1; o.is = rd; o.dn = 1;
        q.push_back(o);
      end
      2'b11: begin
        o.re = 1; o.os = rs; o.pl = 1; o.dn = 1;
        q.push_back(o);
      end
      default: begin
        o.re = 1; o.os = rd; o.as = rs; o.al = 1;
        q.push_back(o);
        for (int i = 0; i < W; i++) q.push_back(obs_t'(0));
        o = '0;
        o.ad = 1; o.rl = 1; o.is = rd; o.as = rs; o.dn = 1;
        q.push_back(o);
      end
    endcase
  endtask

  task automatic model_step();
    obs_t e;
    e = (q.size() != 0) ? q[0] : idle_o();
    if (armed) begin
      nchk++;
      if (act !== e || retired !== mret) begin
        nerr++;
        $display("FAIL model cyc=%0d got=%h/%0d want=%h/%0d",
                 cyc, act, retired, e, mret);
      end
    end
    if (reset) begin
      q.delete();
      mret  = '0;
      armed = 1;
    end else if (armed) begin
      if (e.dn) mret = mret + 1'b1;
      if (q.size() != 0) void'(q.pop_front());
      if (e.rdy && instr_valid)
        push_instr(instr_op, instr_rd, instr_rs, instr_imm);
    end
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] x);
    nchk++;
    if (a !== x) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] rd,
                      input logic [1:0] rs, input logic [7:0] imm);
    int n;
    n = 0;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_imm   = imm;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      nchk++;
      nerr++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    tick();
    instr_valid = 1'b0;
    instr_op    = 2'($urandom);
    instr_rd    = 2'($urandom);
    instr_rs    = 2'($urandom);
    instr_imm   = 8'($urandom);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    instr_imm   = '0;
    fork
      forever begin
        @(negedge clock);
        model_step();
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_retired", 32'(retired), 0);
    check("rst_strobes", 32'(act), 32'(idle_o()));

    send(2'b00, 2'd2, 2'd1, 8'h00);
    check("mov_re", 32'(reg_enable), 1);
    check("mov_os", 32'(out_regselect), 1);
    check("mov_rl", 32'(reg_load), 1);
    check("mov_is", 32'(in_regselect), 2);
    check("mov_done", 32'(done), 1);
    tick();
    check("mov_ready2", 32'(instr_ready), 1);
    check("mov_retired", 32'(retired), 1);

    instr_op    = 2'b01;
    instr_rd    = 2'd3;
    instr_imm   = 8'hA5;
    instr_valid = 1'b1;
    tick();
    check("ldi_id", 32'(imm_drive), 1);
    check("ldi_ib", 32'(imm_bus), 32'hA5);
    check("ldi_is", 32'(in_regselect), 3);
    check("ldi_busy", 32'(instr_ready), 0);
    tick();
    check("ldi2_not_c1", 32'(imm_drive), 0);
    check("ldi2_ready_c2", 32'(instr_ready), 1);
    tick();
    check("ldi2_accept_c2", 32'(imm_drive), 1);
    instr_valid = 1'b0;
    tick();
    check("ldi_retired", 32'(retired), 3);

    send(2'b10, 2'd0, 2'd3, 8'h00);
    check("alu_latch", 32'(alu_latch), 1);
    check("alu_a_os", 32'(out_regselect), 0);
    check("alu_a_as", 32'(alu_regselect), 3);
    tick();
    check("alu_wait1", 32'(act), 0);
    tick();
    check("alu_wait2", 32'(act), 0);
    tick();
    check("alu_wb_ad", 32'(alu_drive), 1);
    check("alu_wb_rl", 32'(reg_load), 1);
    check("alu_wb_is", 32'(in_regselect), 0);
    check("alu_wb_done", 32'(done), 1);
    tick();
    check("alu_retired", 32'(retired), 4);

    send(2'b11, 2'd0, 2'd1, 8'h00);
    check("out_pl", 32'(port_load), 1);
    check("out_re", 32'(reg_enable), 1);
    check("out_os", 32'(out_regselect), 1);
    check("out_rl", 32'(reg_load), 0);
    tick();
    check("out_rl2", 32'(reg_load), 0);
    check("out_retired", 32'(retired), 5);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(2'b10, 2'd1, 2'd2, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(instr_ready), 1);
    check("abort_idle", 32'(act), 32'(idle_o()));
    check("abort_retired", 32'(retired), 0);
    tick();
    tick();
    check("abort_no_done", 32'(done | alu_drive), 0);

    for (int i = 0; i < 255; i++)
      send(2'b00, 2'($urandom), 2'($urandom), 8'h00);
    tick();
    check("wrap_pre", 32'(retired), 32'hFF);
    send(2'b00, 2'd1, 2'd1, 8'h00);
    tick();
    check("wrap_zero", 32'(retired), 0);

    for (int i = 0; i < 4000; i++) begin
      send(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
